eeg_wram_addr_sched: RTL and testbench
======================================

// Module: eeg_wram_addr_sched
// PURPOSE
//  Sequences one WRAM convolution read pass: accepts a job (base address, length, repeat count, bank mask),
//  issues the CONV command to the WRAM, then drives one independent read-address stream per masked bank.
//  Waits for the WRAM to return to idle, then pulses DONE. Sits between the layer controller and the WRAM
//  address ports, replacing the per-bank address logic in the PE array.
// PARAMETERS
//  WRAM_NUM_DW  4   number of WRAM banks (one address stream each)
//  WRAM_ADD_AW  13  WRAM address width
//  WRAM_CMD_DW  5   WRAM command width (one-hot)
//  LEN_DW       13  width of words-per-pass field
//  RPT_DW       8   width of pass-repeat field
// PORTS
//  clk           in   1                     clock, all logic on rising edge
//  rst           in   1                     asynchronous active-high reset
//  CFG_VLD       in   1                     job valid
//  CFG_RDY       out  1                     job ready (high only in IDLE)
//  CFG_BASE_ADD  in   WRAM_ADD_AW           first address of each pass
//  CFG_LEN       in   LEN_DW                words per pass (0 treated as 1)
//  CFG_RPT       in   RPT_DW                passes per bank (0 treated as 1)
//  CFG_BANK_MSK  in   WRAM_NUM_DW           banks taking part
//  WRAM_CMD_VLD  out  1                     command valid to WRAM
//  WRAM_CMD_RDY  in   1                     WRAM command ready
//  WRAM_CMD      out  WRAM_CMD_DW           always 5'b00100 (CONV)
//  WRAM_IDX      out  WRAM_NUM_DW           latched bank mask
//  WRAM_IS_IDLE  in   1                     WRAM FSM idle
//  ADD_VLD       out  WRAM_NUM_DW           per-bank address valid
//  ADD_LST       out  WRAM_NUM_DW           per-bank last address of the job
//  ADD_RDY       in   WRAM_NUM_DW           per-bank address ready
//  ADD_ADD       out  WRAM_NUM_DW*WRAM_ADD_AW per-bank address, bank i at [i*AW +: AW]
//  DONE          out  1                     one-cycle pulse on job completion
//  IS_IDLE       out  1                     FSM in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; WRAM_CMD_VLD, ADD_VLD, ADD_LST, DONE, ADD_ADD, WRAM_IDX all 0. CFG_RDY=IS_IDLE=1.
//    Reset asserted mid-job aborts immediately: no DONE, no further beats.
//  All outputs except CFG_RDY/IS_IDLE are registered. Valid-ready: transfer = VLD & RDY.
//    VLD never depends on RDY, and addr/lst hold stable while VLD & ~RDY.
//  FSM one-hot IDLE/CMD/RUN/DRAIN:
//   IDLE : on CFG_VLD & CFG_RDY latch the job (LEN/RPT zero->1) -> CMD.
//          If latched mask==0 -> DRAIN instead (no command, no addresses).
//   CMD  : WRAM_CMD_VLD=1 (asserted the cycle after the job is accepted); on WRAM_CMD_RDY -> RUN.
//          ADD_VLD rises the next cycle.
//   RUN  : each masked bank i runs its own offset counter off (0..LEN-1) and pass counter p (0..RPT-1).
//          ADD_ADD[i] = (BASE+off) mod 2^WRAM_ADD_AW, so addresses wrap at the top of WRAM.
//          Each transfer advances off; at off==LEN-1, off->0 and p++.
//          ADD_LST[i]=1 only on the final beat of the final pass (off==LEN-1 & p==RPT-1).
//          The transfer carrying LST sets bank_done[i] and drops ADD_VLD[i] the next cycle.
//          Unmasked banks: VLD=0, done=1. Banks are independent; RDY stalls on one bank never stall others.
//          When all bank_done -> DRAIN.
//   DRAIN: wait for WRAM_IS_IDLE=1 (checked from the cycle after entry); then DONE=1 for one cycle -> IDLE.
//  Back-to-back jobs: CFG_RDY rises together with the DONE pulse, so a job can be accepted that cycle.
//  CFG_* are ignored outside IDLE; WRAM_IDX holds its value until the next job is accepted.
//  Counters are sized LEN_DW/RPT_DW; max job = 2^LEN_DW-1 words x 2^RPT_DW-1 passes, no overflow.
// TESTING
//  T1 BASE=0x010, LEN=4, RPT=2, MSK=4'b0001, RDY=1:
//     bank0 addrs 10,11,12,13,10,11,12,13; LST only on the 8th beat; one DONE pulse.
//  T2 BASE=0x1FFE, LEN=4, RPT=1, MSK=4'b1111:
//     every bank emits 1FFE,1FFF,0000,0001 (wrap); WRAM_CMD=00100, WRAM_IDX=1111.
//  T3 MSK=1111, random per-bank RDY backpressure (bank2 held low 50 cycles):
//     other banks finish independently; addr/lst stable while stalled; DONE only after bank2's LST.
//  T4 LEN=0, RPT=0, MSK=0010: bank1 issues a single address BASE with LST=1.
//     MSK=0000: no CMD_VLD, no ADD_VLD, DONE once WRAM_IS_IDLE=1.
//  T5 WRAM_IS_IDLE held low 20 cycles after the last LST:
//     DONE is delayed until it rises; a new CFG_VLD in the DONE cycle is accepted.
//  T6 rst pulsed mid-RUN after 3 beats:
//     all VLD/DONE/CMD_VLD low while rst=1; IDLE with CFG_RDY=1 after release; a fresh job completes normally.

Source files
------------

// File: rtl/eeg_wram_addr_sched.sv
// WRAM convolution read-pass sequencer: accepts a job, issues CONV to the WRAM, then runs one
// independent read-address stream per masked bank, waits for WRAM idle and pulses DONE.
module eeg_wram_addr_sched #(
  parameter int WRAM_NUM_DW = 4,
  parameter int WRAM_ADD_AW = 13,
  parameter int WRAM_CMD_DW = 5,
  parameter int LEN_DW      = 13,
  parameter int RPT_DW      = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               CFG_VLD,
  output logic                               CFG_RDY,
  input  logic [WRAM_ADD_AW-1:0]             CFG_BASE_ADD,
  input  logic [LEN_DW-1:0]                  CFG_LEN,
  input  logic [RPT_DW-1:0]                  CFG_RPT,
  input  logic [WRAM_NUM_DW-1:0]             CFG_BANK_MSK,
  output logic                               WRAM_CMD_VLD,
  input  logic                               WRAM_CMD_RDY,
  output logic [WRAM_CMD_DW-1:0]             WRAM_CMD,
  output logic [WRAM_NUM_DW-1:0]             WRAM_IDX,
  input  logic                               WRAM_IS_IDLE,
  output logic [WRAM_NUM_DW-1:0]             ADD_VLD,
  output logic [WRAM_NUM_DW-1:0]             ADD_LST,
  input  logic [WRAM_NUM_DW-1:0]             ADD_RDY,
  output logic [WRAM_NUM_DW*WRAM_ADD_AW-1:0] ADD_ADD,
  output logic                               DONE,
  output logic                               IS_IDLE
);

  localparam logic [WRAM_CMD_DW-1:0] CMD_CONV = WRAM_CMD_DW'(5'b00100);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CMD   = 4'b0010,
    S_RUN   = 4'b0100,
    S_DRAIN = 4'b1000
  } state_t;

  state_t                  state;
  logic [WRAM_ADD_AW-1:0]  base_q;
  logic [LEN_DW-1:0]       len_m1_q;
  logic [RPT_DW-1:0]       rpt_m1_q;
  logic [WRAM_NUM_DW-1:0]  bank_done_q;
  logic [LEN_DW-1:0]       off_q    [WRAM_NUM_DW];
  logic [RPT_DW-1:0]       pass_q   [WRAM_NUM_DW];
  logic [LEN_DW-1:0]       nxt_off  [WRAM_NUM_DW];
  logic [RPT_DW-1:0]       nxt_pass [WRAM_NUM_DW];
  logic [WRAM_NUM_DW-1:0]  nxt_lst;

  assign CFG_RDY  = (state == S_IDLE);
  assign IS_IDLE  = (state == S_IDLE);
  assign WRAM_CMD = CMD_CONV;

  // Next position of each bank's stream, used only when its current beat transfers.
  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < WRAM_NUM_DW; i++) begin
      nxt_off[i]  = off_q[i] + 1'b1;
      nxt_pass[i] = pass_q[i];
      if (off_q[i] == len_m1_q) begin
        nxt_off[i]  = '0;
        nxt_pass[i] = pass_q[i] + 1'b1;
      end
      nxt_lst[i] = (nxt_off[i] == len_m1_q) && (nxt_pass[i] == rpt_m1_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      base_q       <= '0;
      len_m1_q     <= '0;
      rpt_m1_q     <= '0;
      bank_done_q  <= '0;
      WRAM_CMD_VLD <= 1'b0;
      WRAM_IDX     <= '0;
      ADD_VLD      <= '0;
      ADD_LST      <= '0;
      ADD_ADD      <= '0;
      DONE         <= 1'b0;
      // NOTE: the per-bank counter arrays are a few flops each, not a RAM, so they take the reset too.
      for (int i = 0; i < WRAM_NUM_DW; i++) begin
        off_q[i]  <= '0;
        pass_q[i] <= '0;
      end
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (CFG_VLD) begin
            base_q   <= CFG_BASE_ADD;
            len_m1_q <= (CFG_LEN == '0) ? '0 : CFG_LEN - 1'b1;
            rpt_m1_q <= (CFG_RPT == '0) ? '0 : CFG_RPT - 1'b1;
            WRAM_IDX <= CFG_BANK_MSK;
            if (CFG_BANK_MSK == '0) begin
              state <= S_DRAIN;
            end else begin
              state        <= S_CMD;
              WRAM_CMD_VLD <= 1'b1;
            end
          end
        end

        S_CMD: begin
          if (WRAM_CMD_RDY) begin
            WRAM_CMD_VLD <= 1'b0;
            state        <= S_RUN;
            bank_done_q  <= ~WRAM_IDX;
            ADD_VLD      <= WRAM_IDX;
            for (int i = 0; i < WRAM_NUM_DW; i++) begin
              off_q[i]  <= '0;
              pass_q[i] <= '0;
              ADD_ADD[i*WRAM_ADD_AW +: WRAM_ADD_AW] <= base_q;
              ADD_LST[i] <= WRAM_IDX[i] && (len_m1_q == '0) && (rpt_m1_q == '0);
            end
          end
        end

        S_RUN: begin
          // Each bank advances only on its own handshake; a stalled bank never holds the others.
          for (int i = 0; i < WRAM_NUM_DW; i++) begin
            if (ADD_VLD[i] && ADD_RDY[i]) begin
              if (ADD_LST[i]) begin
                ADD_VLD[i]     <= 1'b0;
                ADD_LST[i]     <= 1'b0;
                bank_done_q[i] <= 1'b1;
              end else begin
                off_q[i]   <= nxt_off[i];
                pass_q[i]  <= nxt_pass[i];
                ADD_LST[i] <= nxt_lst[i];
                ADD_ADD[i*WRAM_ADD_AW +: WRAM_ADD_AW] <= base_q + WRAM_ADD_AW'(nxt_off[i]);
              end
            end
          end
          if (&bank_done_q) state <= S_DRAIN;
        end

        S_DRAIN: begin
          if (WRAM_IS_IDLE) begin
            DONE  <= 1'b1;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeg_wram_addr_sched.sv
// Directed bench for eeg_wram_addr_sched: address order and wrap, LST placement, per-bank
// backpressure, zero LEN/RPT/mask jobs, DONE held off by WRAM idle, back-to-back jobs, mid-job reset.
module tb_eeg_wram_addr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        CFG_VLD;
  logic        CFG_RDY;
  logic [12:0] CFG_BASE_ADD;
  logic [12:0] CFG_LEN;
  logic [7:0]  CFG_RPT;
  logic [3:0]  CFG_BANK_MSK;
  logic        WRAM_CMD_VLD;
  logic        WRAM_CMD_RDY;
  logic [4:0]  WRAM_CMD;
  logic [3:0]  WRAM_IDX;
  logic        WRAM_IS_IDLE;
  logic [3:0]  ADD_VLD;
  logic [3:0]  ADD_LST;
  logic [3:0]  ADD_RDY;
  logic [51:0] ADD_ADD;
  logic        DONE;
  logic        IS_IDLE;

  int tests_run    = 0;
  int tests_failed = 0;

  // Captured beats and event cycles of the most recent job.
  logic [12:0] b_add [4][64];
  logic        b_lst [4][64];
  int          nb    [4];
  int          lst_c [4];
  int          done_cnt, done_c, cmd_cnt, stab_err;

  eeg_wram_addr_sched dut (
    .clk          (clk),
    .rst          (rst),
    .CFG_VLD      (CFG_VLD),
    .CFG_RDY      (CFG_RDY),
    .CFG_BASE_ADD (CFG_BASE_ADD),
    .CFG_LEN      (CFG_LEN),
    .CFG_RPT      (CFG_RPT),
    .CFG_BANK_MSK (CFG_BANK_MSK),
    .WRAM_CMD_VLD (WRAM_CMD_VLD),
    .WRAM_CMD_RDY (WRAM_CMD_RDY),
    .WRAM_CMD     (WRAM_CMD),
    .WRAM_IDX     (WRAM_IDX),
    .WRAM_IS_IDLE (WRAM_IS_IDLE),
    .ADD_VLD      (ADD_VLD),
    .ADD_LST      (ADD_LST),
    .ADD_RDY      (ADD_RDY),
    .ADD_ADD      (ADD_ADD),
    .DONE         (DONE),
    .IS_IDLE      (IS_IDLE)
  );

  always #5 clk = ~clk;

  // Presents a job while CFG_RDY is high, then scrambles CFG_* so later cycles prove they are ignored.
  // Returns #1 after the accepting edge.
  task automatic start_job(input logic [12:0] base, input logic [12:0] len,
                           input logic [7:0] rpt, input logic [3:0] msk);
    int w = 0;
    while (!CFG_RDY && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    tests_run++;
    if (CFG_RDY !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_job_cfg_rdy: got %b, want 1 within 200 cycles", CFG_RDY);
    end
    CFG_VLD      = 1'b1;
    CFG_BASE_ADD = base;
    CFG_LEN      = len;
    CFG_RPT      = rpt;
    CFG_BANK_MSK = msk;
    @(posedge clk); #1;
    CFG_VLD      = 1'b0;
    CFG_BASE_ADD = 13'h0BAD;
    CFG_LEN      = 13'd7;
    CFG_RPT      = 8'd3;
    CFG_BANK_MSK = 4'b0101;
  endtask

  // Runs the job cycle by cycle from the cycle after acceptance (c=0) until DONE is seen.
  // mode 0: all ADD_RDY high; mode 1: random per-bank RDY with bank2 held low for 50 cycles.
  // idle_hold>0: WRAM_IS_IDLE stays low until idle_hold cycles after the final LST transfer.
  // Returns #1 into the DONE cycle.
  task automatic run_job(input logic [3:0] msk, input int mode, input int idle_hold, input int budget);
    logic [3:0]  rdy;
    logic [3:0]  stall_q = '0;
    logic [12:0] padd [4];
    logic        plst [4];
    int          lst_left = $countones(msk);
    int          last_c   = -1;
    for (int i = 0; i < 4; i++) begin
      nb[i]    = 0;
      lst_c[i] = -1;
    end
    done_cnt = 0; done_c = -1; cmd_cnt = 0; stab_err = 0;
    WRAM_IS_IDLE = (idle_hold == 0);
    for (int c = 0; c < budget; c++) begin
      if (WRAM_CMD_VLD) cmd_cnt++;
      if (DONE) begin
        done_cnt++;
        done_c = c;
        break;
      end
      for (int i = 0; i < 4; i++) begin
        if (mode == 0)                rdy[i] = 1'b1;
        else if (i == 2 && c < 50)    rdy[i] = 1'b0;
        else                          rdy[i] = 1'($urandom_range(0, 1));
        if (stall_q[i] && (!ADD_VLD[i] || ADD_ADD[i*13 +: 13] !== padd[i] || ADD_LST[i] !== plst[i]))
          stab_err++;
        if (ADD_VLD[i] && rdy[i]) begin
          if (nb[i] < 64) begin
            b_add[i][nb[i]] = ADD_ADD[i*13 +: 13];
            b_lst[i][nb[i]] = ADD_LST[i];
          end
          nb[i]++;
          if (ADD_LST[i]) begin
            lst_c[i] = c;
            lst_left--;
            if (lst_left == 0) last_c = c;
          end
        end
        stall_q[i] = ADD_VLD[i] & ~rdy[i];
        padd[i]    = ADD_ADD[i*13 +: 13];
        plst[i]    = ADD_LST[i];
      end
      ADD_RDY = rdy;
      if (idle_hold > 0 && last_c >= 0 && c >= last_c + idle_hold) WRAM_IS_IDLE = 1'b1;
      @(posedge clk); #1;
    end
    WRAM_IS_IDLE = 1'b1;
    ADD_RDY      = 4'b1111;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({CFG_RDY, IS_IDLE} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_rdy_idle: got %b, want 11", {CFG_RDY, IS_IDLE});
    end
    tests_run++;
    if ({WRAM_CMD_VLD, ADD_VLD, ADD_LST, DONE} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_valids: got %b, want 0", {WRAM_CMD_VLD, ADD_VLD, ADD_LST, DONE});
    end
    tests_run++;
    if ({ADD_ADD, WRAM_IDX} !== 56'b0) begin
      tests_failed++;
      $display("FAIL reset_add_idx: got %h/%b, want 0/0", ADD_ADD, WRAM_IDX);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // T1: one bank, two passes of four words.
  task automatic test_basic();
    logic [12:0] e;
    start_job(13'h010, 13'd4, 8'd2, 4'b0001);
    run_job(4'b0001, 0, 0, 200);
    tests_run++;
    if (nb[0] != 8 || nb[1] + nb[2] + nb[3] != 0) begin
      tests_failed++;
      $display("FAIL t1_beat_count: got %0d/%0d, want 8/0", nb[0], nb[1] + nb[2] + nb[3]);
    end
    for (int k = 0; k < 8 && k < nb[0]; k++) begin
      e = 13'h010 + 13'(k % 4);
      tests_run++;
      if (b_add[0][k] !== e || b_lst[0][k] !== (k == 7)) begin
        tests_failed++;
        $display("FAIL t1_beat%0d: got %h lst=%b, want %h lst=%b", k, b_add[0][k], b_lst[0][k], e, k == 7);
      end
    end
    tests_run++;
    if (done_cnt != 1 || cmd_cnt != 1 || done_c != lst_c[0] + 3) begin
      tests_failed++;
      $display("FAIL t1_done: got done=%0d cmd=%0d at c%0d, want 1/1 at c%0d", done_cnt, cmd_cnt, done_c, lst_c[0] + 3);
    end
    @(posedge clk); #1;
    tests_run++;
    if (DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_done_pulse: got %b one cycle later, want 0", DONE);
    end
  endtask

  // T2: all banks, address wrap at the top of WRAM.
  task automatic test_wrap();
    logic [12:0] e;
    start_job(13'h1FFE, 13'd4, 8'd1, 4'b1111);
    tests_run++;
    if (WRAM_CMD_VLD !== 1'b1 || WRAM_CMD !== 5'b00100 || WRAM_IDX !== 4'b1111 || IS_IDLE !== 1'b0) begin
      tests_failed++;
      $display("FAIL t2_cmd: got vld=%b cmd=%b idx=%b idle=%b, want 1/00100/1111/0", WRAM_CMD_VLD, WRAM_CMD, WRAM_IDX, IS_IDLE);
    end
    run_job(4'b1111, 0, 0, 200);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (nb[i] != 4) begin
        tests_failed++;
        $display("FAIL t2_count_bank%0d: got %0d, want 4", i, nb[i]);
      end
      for (int k = 0; k < 4 && k < nb[i]; k++) begin
        e = 13'h1FFE + 13'(k);
        tests_run++;
        if (b_add[i][k] !== e || b_lst[i][k] !== (k == 3)) begin
          tests_failed++;
          $display("FAIL t2_bank%0d_beat%0d: got %h lst=%b, want %h lst=%b", i, k, b_add[i][k], b_lst[i][k], e, k == 3);
        end
      end
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL t2_done: got %0d pulses, want 1", done_cnt);
    end
  endtask

  // T3: random per-bank backpressure, bank2 stalled for 50 cycles.
  task automatic test_backpressure();
    logic [12:0] e;
    start_job(13'h300, 13'd5, 8'd2, 4'b1111);
    run_job(4'b1111, 1, 0, 400);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (nb[i] != 10) begin
        tests_failed++;
        $display("FAIL t3_count_bank%0d: got %0d, want 10", i, nb[i]);
      end
      for (int k = 0; k < 10 && k < nb[i]; k++) begin
        e = 13'h300 + 13'(k % 5);
        tests_run++;
        if (b_add[i][k] !== e || b_lst[i][k] !== (k == 9)) begin
          tests_failed++;
          $display("FAIL t3_bank%0d_beat%0d: got %h lst=%b, want %h lst=%b", i, k, b_add[i][k], b_lst[i][k], e, k == 9);
        end
      end
    end
    tests_run++;
    if (stab_err != 0) begin
      tests_failed++;
      $display("FAIL t3_stall_stable: got %0d unstable stalled cycles, want 0", stab_err);
    end
    tests_run++;
    if (lst_c[0] < 0 || lst_c[0] >= 50 || lst_c[1] < 0 || lst_c[1] >= 50 || lst_c[3] < 0 || lst_c[3] >= 50) begin
      tests_failed++;
      $display("FAIL t3_independent: got lst cycles %0d/%0d/%0d, want all in 0..49", lst_c[0], lst_c[1], lst_c[3]);
    end
    tests_run++;
    if (done_cnt != 1 || lst_c[2] < 50 || done_c != lst_c[2] + 3) begin
      tests_failed++;
      $display("FAIL t3_done: got done=%0d at c%0d (bank2 lst c%0d), want 1 at c%0d", done_cnt, done_c, lst_c[2], lst_c[2] + 3);
    end
  endtask

  // T4: LEN=RPT=0 on bank1, then an empty mask.
  task automatic test_zero_job();
    start_job(13'h0AB, 13'd0, 8'd0, 4'b0010);
    run_job(4'b0010, 0, 0, 100);
    tests_run++;
    if (nb[1] != 1 || b_add[1][0] !== 13'h0AB || b_lst[1][0] !== 1'b1 || nb[0] + nb[2] + nb[3] != 0) begin
      tests_failed++;
      $display("FAIL t4_single: got n=%0d %h lst=%b others=%0d, want 1 0ab lst=1 others=0", nb[1], b_add[1][0], b_lst[1][0], nb[0] + nb[2] + nb[3]);
    end
    tests_run++;
    if (done_cnt != 1 || done_c != 4) begin
      tests_failed++;
      $display("FAIL t4_single_done: got %0d at c%0d, want 1 at c4", done_cnt, done_c);
    end
    @(posedge clk); #1;
    start_job(13'h123, 13'd3, 8'd2, 4'b0000);
    tests_run++;
    if (WRAM_CMD_VLD !== 1'b0 || WRAM_IDX !== 4'b0000) begin
      tests_failed++;
      $display("FAIL t4_empty_cmd: got vld=%b idx=%b, want 0/0000", WRAM_CMD_VLD, WRAM_IDX);
    end
    run_job(4'b0000, 0, 0, 100);
    tests_run++;
    if (done_cnt != 1 || done_c != 1 || cmd_cnt != 0 || nb[0] + nb[1] + nb[2] + nb[3] != 0) begin
      tests_failed++;
      $display("FAIL t4_empty: got done=%0d at c%0d cmd=%0d beats=%0d, want 1 at c1, 0, 0", done_cnt, done_c, cmd_cnt, nb[0] + nb[1] + nb[2] + nb[3]);
    end
  endtask

  // T5: WRAM idle held off 20 cycles, then a job accepted in the DONE cycle.
  task automatic test_back_to_back();
    start_job(13'h020, 13'd3, 8'd1, 4'b0100);
    run_job(4'b0100, 0, 20, 200);
    tests_run++;
    if (nb[2] != 3 || b_add[2][2] !== 13'h022 || b_lst[2][2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL t5_beats: got n=%0d last=%h lst=%b, want 3 022 1", nb[2], b_add[2][2], b_lst[2][2]);
    end
    tests_run++;
    if (done_cnt != 1 || done_c != lst_c[2] + 21) begin
      tests_failed++;
      $display("FAIL t5_done_delay: got done=%0d at c%0d, want 1 at c%0d", done_cnt, done_c, lst_c[2] + 21);
    end
    tests_run++;
    if (CFG_RDY !== 1'b1) begin
      tests_failed++;
      $display("FAIL t5_rdy_with_done: got %b, want 1", CFG_RDY);
    end
    start_job(13'h1FFF, 13'd2, 8'd1, 4'b1000);
    tests_run++;
    if (WRAM_CMD_VLD !== 1'b1 || WRAM_IDX !== 4'b1000) begin
      tests_failed++;
      $display("FAIL t5_accept: got vld=%b idx=%b, want 1/1000", WRAM_CMD_VLD, WRAM_IDX);
    end
    run_job(4'b1000, 0, 0, 100);
    tests_run++;
    if (nb[3] != 2 || b_add[3][0] !== 13'h1FFF || b_add[3][1] !== 13'h0000 || b_lst[3][1] !== 1'b1 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL t5_second: got n=%0d %h,%h lst=%b done=%0d, want 2 1fff,0000 1 1", nb[3], b_add[3][0], b_add[3][1], b_lst[3][1], done_cnt);
    end
  endtask

  // T6: reset after three beats, then a fresh job.
  task automatic test_reset_mid_run();
    logic [12:0] e;
    ADD_RDY = 4'b1111;
    start_job(13'h100, 13'd8, 8'd1, 4'b0001);
    repeat (4) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (ADD_VLD[0] !== 1'b1 || ADD_ADD[12:0] !== 13'h103) begin
      tests_failed++;
      $display("FAIL t6_pre_reset: got vld=%b add=%h, want 1 103", ADD_VLD[0], ADD_ADD[12:0]);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if ({WRAM_CMD_VLD, ADD_VLD, DONE} !== 6'b0 || CFG_RDY !== 1'b1) begin
        tests_failed++;
        $display("FAIL t6_in_reset%0d: got vld/done=%b rdy=%b, want 0 and 1", c, {WRAM_CMD_VLD, ADD_VLD, DONE}, CFG_RDY);
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({WRAM_CMD_VLD, ADD_VLD, DONE} !== 6'b0 || {CFG_RDY, IS_IDLE} !== 2'b11) begin
        tests_failed++;
        $display("FAIL t6_after_reset%0d: got vld/done=%b rdy/idle=%b, want 0 and 11", c, {WRAM_CMD_VLD, ADD_VLD, DONE}, {CFG_RDY, IS_IDLE});
      end
    end
    start_job(13'h055, 13'd3, 8'd2, 4'b0011);
    run_job(4'b0011, 0, 0, 200);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (nb[i] != 6) begin
        tests_failed++;
        $display("FAIL t6_count_bank%0d: got %0d, want 6", i, nb[i]);
      end
      for (int k = 0; k < 6 && k < nb[i]; k++) begin
        e = 13'h055 + 13'(k % 3);
        tests_run++;
        if (b_add[i][k] !== e || b_lst[i][k] !== (k == 5)) begin
          tests_failed++;
          $display("FAIL t6_bank%0d_beat%0d: got %h lst=%b, want %h lst=%b", i, k, b_add[i][k], b_lst[i][k], e, k == 5);
        end
      end
    end
    tests_run++;
    if (done_cnt != 1 || nb[2] + nb[3] != 0) begin
      tests_failed++;
      $display("FAIL t6_done: got done=%0d stray=%0d, want 1 0", done_cnt, nb[2] + nb[3]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    CFG_VLD      = 1'b0;
    CFG_BASE_ADD = '0;
    CFG_LEN      = '0;
    CFG_RPT      = '0;
    CFG_BANK_MSK = '0;
    WRAM_CMD_RDY = 1'b1;
    WRAM_IS_IDLE = 1'b1;
    ADD_RDY      = 4'b1111;

    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_job();
    test_back_to_back();
    test_reset_mid_run();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
